// File: rtl/ps2_digit_ctrl.sv
// PS/2 scan-code set 2 decoder that shifts hex digit keys into a 4-digit LED entry buffer.
// Build option: define KEY_REPEAT_EN to process typematic repeats as fresh key presses.
module ps2_digit_ctrl #(
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [3:0]  BLANK_CODE     = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_en,
  output logic       key_stb,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_BKSP = 8'h66;
  localparam logic [7:0] CODE_ESC  = 8'h76;

  state_t        state_q, state_d;
  logic [7:0]    held_q, held_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   dig_q, dig_d;
  logic [3:0]    en_q, en_d;
  logic          stb_q, stb_d;
  logic [4:0]    hex;
  logic          is_repeat;

  // Returns {is_hex, value}; main row and keypad both map onto 0-F.
  function automatic logic [4:0] hex_decode(input logic [7:0] code);
    logic [4:0] r;
    r = 5'h00;
    case (code)
      8'h45, 8'h70: r = {1'b1, 4'h0};
      8'h16, 8'h69: r = {1'b1, 4'h1};
      8'h1E, 8'h72: r = {1'b1, 4'h2};
      8'h26, 8'h7A: r = {1'b1, 4'h3};
      8'h25, 8'h6B: r = {1'b1, 4'h4};
      8'h2E, 8'h73: r = {1'b1, 4'h5};
      8'h36, 8'h74: r = {1'b1, 4'h6};
      8'h3D, 8'h6C: r = {1'b1, 4'h7};
      8'h3E, 8'h75: r = {1'b1, 4'h8};
      8'h46, 8'h7D: r = {1'b1, 4'h9};
      8'h1C:        r = {1'b1, 4'hA};
      8'h32:        r = {1'b1, 4'hB};
      8'h21:        r = {1'b1, 4'hC};
      8'h23:        r = {1'b1, 4'hD};
      8'h24:        r = {1'b1, 4'hE};
      8'h2B:        r = {1'b1, 4'hF};
      default:      r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    en_d    = en_q;
    stb_d   = 1'b0;
    hex     = hex_decode(rx_data);
`ifdef KEY_REPEAT_EN
    is_repeat = 1'b0;
`else
    is_repeat = (rx_data == held_q);
`endif

    if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        S_IDLE: begin
          if (rx_data == CODE_BRK) begin
            state_d = S_BRK;
          end else if (rx_data == CODE_EXT) begin
            state_d = S_EXT;
          end else if (!is_repeat) begin
            held_d = rx_data;
            if (hex[4]) begin
              dig_d = {dig_q[11:0], hex[3:0]};
              en_d  = {en_q[2:0], 1'b1};
              stb_d = 1'b1;
            end else if (rx_data == CODE_BKSP) begin
              if (en_q != 4'b0000) begin
                dig_d = {BLANK_CODE, dig_q[15:4]};
                en_d  = {1'b0, en_q[3:1]};
                stb_d = 1'b1;
              end
            end else if (rx_data == CODE_ESC) begin
              dig_d = {4{BLANK_CODE}};
              en_d  = 4'b0000;
              stb_d = 1'b1;
            end
          end
        end
        S_BRK: begin
          if (rx_data == held_q) held_d = 8'h00;
          state_d = S_IDLE;
        end
        S_EXT: begin
          state_d = (rx_data == CODE_BRK) ? S_EXT_BRK : S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      // A prefix whose follow-up byte never arrives is dropped silently.
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      held_q  <= 8'h00;
      cnt_q   <= '0;
      dig_q   <= {4{BLANK_CODE}};
      en_q    <= 4'b0000;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      en_q    <= en_d;
      stb_q   <= stb_d;
    end
  end

  assign digit3    = dig_q[15:12];
  assign digit2    = dig_q[11:8];
  assign digit1    = dig_q[7:4];
  assign digit0    = dig_q[3:0];
  assign digit_en  = en_q;
  assign key_stb   = stb_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_digit_ctrl.sv
// Self-checking bench for ps2_digit_ctrl: vector table of scan-code bytes plus
// hand-written back-to-back, timeout and mid-sequence reset sequences.
module tb_ps2_digit_ctrl;

  localparam int T = 200;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] digit0, digit1, digit2, digit3, digit_en;
  logic       key_stb;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Expected record layout: {digits3..0, digit_en, key_stb, state}
  logic [22:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [7:0]  b;
    logic [15:0] dig;
    logic [3:0]  en;
    logic        stb;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];

  ps2_digit_ctrl #(.TIMEOUT_CYCLES(T), .BLANK_CODE(4'hF)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .digit_en  (digit_en),
    .key_stb   (key_stb),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [22:0] pk(input logic [15:0] dig, input logic [3:0] en,
                                     input logic stb, input logic [1:0] st);
    return {dig, en, stb, st};
  endfunction

  function automatic void add(input logic [7:0] b, input logic [15:0] dig,
                              input logic [3:0] en, input logic stb, input logic [1:0] st);
    vec_t v;
    v.b = b; v.dig = dig; v.en = en; v.stb = stb; v.st = st;
    vecs.push_back(v);
  endfunction

  task automatic check_out(input string name, input logic [22:0] exp);
    logic [22:0] got;
    got = {digit3, digit2, digit1, digit0, digit_en, key_stb, state_dbg};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got dig=%h en=%b stb=%b st=%0d exp dig=%h en=%b stb=%b st=%0d",
               name, got[22:7], got[6:3], got[2], got[1:0],
               exp[22:7], exp[6:3], exp[2], exp[1:0]);
    end
  endtask

  // driver: retire the previous byte's expectation, then present the next byte
  task automatic drive_byte(input logic [7:0] b, input logic [22:0] exp, input string name);
    @(negedge clk);
    if (exp_q.size() > 0) check_out(name_q.pop_front(), exp_q.pop_front());
    rx_data  = b;
    rx_valid = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic flush();
    @(negedge clk);
    rx_valid = 1'b0;
    if (exp_q.size() > 0) check_out(name_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] rep_dig;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    repeat (2) @(negedge clk);
    check_out("reset", pk(16'hFFFF, 4'b0000, 1'b0, 2'd0));
    reset = 1'b0;

`ifdef KEY_REPEAT_EN
    rep_dig = 16'h5AAA;
`else
    rep_dig = 16'h345A;
`endif

    // five digits entered, oldest dropped
    add(8'h16, 16'hFFF1, 4'h1, 1, 0); add(8'hF0, 16'hFFF1, 4'h1, 0, 1); add(8'h16, 16'hFFF1, 4'h1, 0, 0);
    add(8'h1E, 16'hFF12, 4'h3, 1, 0); add(8'hF0, 16'hFF12, 4'h3, 0, 1); add(8'h1E, 16'hFF12, 4'h3, 0, 0);
    add(8'h26, 16'hF123, 4'h7, 1, 0); add(8'hF0, 16'hF123, 4'h7, 0, 1); add(8'h26, 16'hF123, 4'h7, 0, 0);
    add(8'h25, 16'h1234, 4'hF, 1, 0); add(8'hF0, 16'h1234, 4'hF, 0, 1); add(8'h25, 16'h1234, 4'hF, 0, 0);
    add(8'h2E, 16'h2345, 4'hF, 1, 0); add(8'hF0, 16'h2345, 4'hF, 0, 1); add(8'h2E, 16'h2345, 4'hF, 0, 0);
    // typematic repeat of A
    add(8'h1C, 16'h345A, 4'hF, 1, 0);
`ifdef KEY_REPEAT_EN
    add(8'h1C, 16'h45AA, 4'hF, 1, 0); add(8'h1C, 16'h5AAA, 4'hF, 1, 0);
`else
    add(8'h1C, 16'h345A, 4'hF, 0, 0); add(8'h1C, 16'h345A, 4'hF, 0, 0);
`endif
    add(8'hF0, rep_dig, 4'hF, 0, 1); add(8'h1C, rep_dig, 4'hF, 0, 0);
    // escape, then escape on an empty buffer still strobes
    add(8'h76, 16'hFFFF, 4'h0, 1, 0); add(8'hF0, 16'hFFFF, 4'h0, 0, 1); add(8'h76, 16'hFFFF, 4'h0, 0, 0);
    add(8'h76, 16'hFFFF, 4'h0, 1, 0); add(8'hF0, 16'hFFFF, 4'h0, 0, 1); add(8'h76, 16'hFFFF, 4'h0, 0, 0);
    // backspace down to empty, then backspace no-op
    add(8'h1E, 16'hFFF2, 4'h1, 1, 0); add(8'hF0, 16'hFFF2, 4'h1, 0, 1); add(8'h1E, 16'hFFF2, 4'h1, 0, 0);
    add(8'h26, 16'hFF23, 4'h3, 1, 0); add(8'hF0, 16'hFF23, 4'h3, 0, 1); add(8'h26, 16'hFF23, 4'h3, 0, 0);
    add(8'h66, 16'hFFF2, 4'h1, 1, 0); add(8'hF0, 16'hFFF2, 4'h1, 0, 1); add(8'h66, 16'hFFF2, 4'h1, 0, 0);
    add(8'h66, 16'hFFFF, 4'h0, 1, 0); add(8'hF0, 16'hFFFF, 4'h0, 0, 1); add(8'h66, 16'hFFFF, 4'h0, 0, 0);
    add(8'h66, 16'hFFFF, 4'h0, 0, 0); add(8'hF0, 16'hFFFF, 4'h0, 0, 1); add(8'h66, 16'hFFFF, 4'h0, 0, 0);
    // extended sequences are ignored
    add(8'h45, 16'hFFF0, 4'h1, 1, 0); add(8'hF0, 16'hFFF0, 4'h1, 0, 1); add(8'h45, 16'hFFF0, 4'h1, 0, 0);
    add(8'hE0, 16'hFFF0, 4'h1, 0, 2); add(8'h70, 16'hFFF0, 4'h1, 0, 0);
    add(8'hE0, 16'hFFF0, 4'h1, 0, 2); add(8'hF0, 16'hFFF0, 4'h1, 0, 3); add(8'h70, 16'hFFF0, 4'h1, 0, 0);
    // keypad 0, F key, non-hex key, keypad 9
    add(8'h70, 16'hFF00, 4'h3, 1, 0); add(8'hF0, 16'hFF00, 4'h3, 0, 1); add(8'h70, 16'hFF00, 4'h3, 0, 0);
    add(8'h2B, 16'hF00F, 4'h7, 1, 0); add(8'hF0, 16'hF00F, 4'h7, 0, 1); add(8'h2B, 16'hF00F, 4'h7, 0, 0);
    add(8'h29, 16'hF00F, 4'h7, 0, 0); add(8'hF0, 16'hF00F, 4'h7, 0, 1); add(8'h29, 16'hF00F, 4'h7, 0, 0);
    add(8'h7D, 16'h00F9, 4'hF, 1, 0); add(8'hF0, 16'h00F9, 4'hF, 0, 1); add(8'h7D, 16'h00F9, 4'hF, 0, 0);
    add(8'h76, 16'hFFFF, 4'h0, 1, 0); add(8'hF0, 16'hFFFF, 4'h0, 0, 1); add(8'h76, 16'hFFFF, 4'h0, 0, 0);

    foreach (vecs[i]) begin
      drive_byte(vecs[i].b, pk(vecs[i].dig, vecs[i].en, vecs[i].stb, vecs[i].st),
                 $sformatf("vec%0d_%h", i, vecs[i].b));
      flush();
    end

    // back-to-back bytes, one per cycle
    drive_byte(8'h16, pk(16'hFFF1, 4'h1, 1, 0), "b2b_1");
    drive_byte(8'h1E, pk(16'hFF12, 4'h3, 1, 0), "b2b_2");
    drive_byte(8'h26, pk(16'hF123, 4'h7, 1, 0), "b2b_3");
    drive_byte(8'hF0, pk(16'hF123, 4'h7, 0, 1), "b2b_f0");
    drive_byte(8'h26, pk(16'hF123, 4'h7, 0, 0), "b2b_brk");
    drive_byte(8'h76, pk(16'hFFFF, 4'h0, 1, 0), "b2b_esc");
    drive_byte(8'hF0, pk(16'hFFFF, 4'h0, 0, 1), "b2b_esc_f0");
    drive_byte(8'h76, pk(16'hFFFF, 4'h0, 0, 0), "b2b_esc_brk");
    flush();

    // prefix still pending shortly before the timeout: 3D is a break, not a make
    drive_byte(8'hF0, pk(16'hFFFF, 4'h0, 0, 1), "pre_to_f0");
    flush();
    idle(T - 3);
    check_out("pre_to_pending", pk(16'hFFFF, 4'h0, 0, 1));
    drive_byte(8'h3D, pk(16'hFFFF, 4'h0, 0, 0), "pre_to_brk");
    flush();

    // stalled prefix times out at exactly T cycles
    drive_byte(8'hF0, pk(16'hFFFF, 4'h0, 0, 1), "to_f0");
    flush();
    idle(T - 1);
    check_out("to_last_cycle", pk(16'hFFFF, 4'h0, 0, 1));
    idle(1);
    check_out("to_idle", pk(16'hFFFF, 4'h0, 0, 0));
    drive_byte(8'h45, pk(16'hFFF0, 4'h1, 1, 0), "to_make");
    flush();

    // reset between F0 and its byte discards the prefix and held key
    drive_byte(8'hF0, pk(16'hFFF0, 4'h1, 0, 1), "rst_f0");
    flush();
    reset = 1'b1;
    @(negedge clk);
    check_out("rst_mid", pk(16'hFFFF, 4'h0, 0, 0));
    reset = 1'b0;
    drive_byte(8'h45, pk(16'hFFF0, 4'h1, 1, 0), "rst_make");
    drive_byte(8'hF0, pk(16'hFFF0, 4'h1, 0, 1), "rst_make_f0");
    drive_byte(8'h45, pk(16'hFFF0, 4'h1, 0, 0), "rst_make_brk");
    flush();

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
